// File: rtl/alarm_pkg.sv
// Shared types and BCD limits for the alarm initiator.
package alarm_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, RINGING, SNOOZE} alarm_state_e;

  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] SEC_ZERO = 8'h00;
endpackage

// File: rtl/alarm_trigger_bcd_inc.sv
// Combinational 2-digit BCD increment that wraps to 00 after the given limit.
module bcd_inc (
  input  logic [7:0] val,
  input  logic [7:0] lim,
  output logic [7:0] nxt
);
  always_comb begin
    nxt = 8'h00;
    if (val == lim)
      nxt = 8'h00;
    else if (val[3:0] >= 4'h9)
      nxt = {val[7:4] + 4'h1, 4'h0};
    else
      nxt = {val[7:4], val[3:0] + 4'h1};
  end
endmodule

// File: rtl/alarm_trigger.sv
// Alarm initiator: BCD alarm time, match edge detect, ring/snooze/ack sequencing.
// Build option HOURLY_CHIME_EN adds chime_en and a top-of-hour bing.
module alarm_trigger
  import alarm_pkg::*;
#(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int CNT_W          = 10
) (
  input  logic       clk,
  input  logic       CLR_n,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  input  logic       sec_tick,
  input  logic       set_mode,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       alarm_en,
  input  logic       ack_btn,
  input  logic       snooze_btn,
`ifdef HOURLY_CHIME_EN
  input  logic       chime_en,
`endif
  output logic       bing,
  output logic [7:0] alarm_hour,
  output logic [7:0] alarm_min,
  output logic       alarm_active
);
  localparam logic [CNT_W-1:0] RING_LD = CNT_W'(RING_TIMEOUT_S);
  localparam logic [CNT_W-1:0] SNZ_LD  = CNT_W'(SNOOZE_MIN * 60);

  alarm_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_now, match_q, match_rise;
  logic             fire, chime_fire, bing_d;
  logic [7:0]       hour_nxt, min_nxt;

  bcd_inc u_hour_inc (.val(alarm_hour), .lim(HOUR_MAX), .nxt(hour_nxt));
  bcd_inc u_min_inc  (.val(alarm_min),  .lim(MIN_MAX),  .nxt(min_nxt));

  always_ff @(posedge clk or posedge CLR_n) begin
    if (CLR_n) begin
      alarm_hour <= 8'h00;
      alarm_min  <= 8'h00;
    end else if (set_mode) begin
      if (inc_hour) alarm_hour <= hour_nxt;
      if (inc_min)  alarm_min  <= min_nxt;
    end
  end

  assign match_now  = (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == SEC_ZERO);
  assign match_rise = match_now & ~match_q;

`ifdef HOURLY_CHIME_EN
  logic chime_now, chime_q;
  assign chime_now  = (cur_min == 8'h00) && (cur_sec == SEC_ZERO);
  assign chime_fire = chime_en & ~set_mode & chime_now & ~chime_q;

  always_ff @(posedge clk or posedge CLR_n) begin
    if (CLR_n) chime_q <= 1'b0;
    else       chime_q <= chime_now;
  end
`else
  assign chime_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    if (!alarm_en || set_mode) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARMED;
          cnt_d   = '0;
        end
        ARMED: begin
          cnt_d = '0;
          if (match_rise) begin
            state_d = RINGING;
            cnt_d   = RING_LD;
            fire    = 1'b1;
          end
        end
        RINGING: begin
          if (ack_btn) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else if (snooze_btn) begin
            state_d = SNOOZE;
            cnt_d   = SNZ_LD;
          end else if (cnt_q == '0) begin
            state_d = ARMED;
          end else if (sec_tick) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        SNOOZE: begin
          if (ack_btn) begin
            state_d = ARMED;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            state_d = RINGING;
            cnt_d   = RING_LD;
            fire    = 1'b1;
          end else if (sec_tick) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Coincident chime and alarm merge into one pulse; never back-to-back.
  assign bing_d = (fire | chime_fire) & ~bing;

  always_ff @(posedge clk or posedge CLR_n) begin
    if (CLR_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      match_q <= 1'b0;
      bing    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      match_q <= match_now;
      bing    <= bing_d;
    end
  end

  assign alarm_active = (state_q == RINGING);
endmodule

// File: tb/tb_alarm_trigger.sv
// Self-checking bench for alarm_trigger: setting table plus ring/snooze/reset sequences.
module tb_alarm_trigger;
  logic       clk = 1'b0;
  logic       CLR_n = 1'b0;
  logic [7:0] cur_hour = 8'h12, cur_min = 8'h00, cur_sec = 8'h01;
  logic       sec_tick = 0, set_mode = 0, inc_hour = 0, inc_min = 0;
  logic       alarm_en = 0, ack_btn = 0, snooze_btn = 0, chime_en = 0;
  logic       bing, alarm_active;
  logic [7:0] alarm_hour, alarm_min;

  alarm_trigger dut (
    .clk(clk), .CLR_n(CLR_n), .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .sec_tick(sec_tick), .set_mode(set_mode), .inc_hour(inc_hour), .inc_min(inc_min),
    .alarm_en(alarm_en), .ack_btn(ack_btn), .snooze_btn(snooze_btn),
`ifdef HOURLY_CHIME_EN
    .chime_en(chime_en),
`endif
    .bing(bing), .alarm_hour(alarm_hour), .alarm_min(alarm_min), .alarm_active(alarm_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       bing;
    logic       act;
    logic [7:0] hr;
    logic [7:0] mn;
  } exp_t;

  typedef struct {
    logic       sm;
    logic       ih;
    logic       im;
    logic [7:0] eh;
    logic [7:0] em;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[$];
  int         n_run = 0, n_fail = 0;
  logic [7:0] ah_exp = 8'h00, am_exp = 8'h00;

  function automatic logic [7:0] to_bcd(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic push_exp(string nm, logic eb, logic ea);
    exp_t e;
    e.nm = nm; e.bing = eb; e.act = ea; e.hr = ah_exp; e.mn = am_exp;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    e = sb.pop_front();
    n_run++;
    if (bing !== e.bing || alarm_active !== e.act || alarm_hour !== e.hr || alarm_min !== e.mn) begin
      n_fail++;
      $display("FAIL %s: got bing=%b act=%b alarm=%h:%h, want bing=%b act=%b alarm=%h:%h",
               e.nm, bing, alarm_active, alarm_hour, alarm_min, e.bing, e.act, e.hr, e.mn);
    end
  endtask

  // One clock with the currently driven inputs; pulses are cleared afterwards.
  task automatic cyc(string nm, logic eb, logic ea);
    push_exp(nm, eb, ea);
    @(posedge clk); #1;
    compare();
    inc_hour = 0; inc_min = 0; ack_btn = 0; snooze_btn = 0; sec_tick = 0;
  endtask

  task automatic async_chk(string nm);
    push_exp(nm, 1'b0, 1'b0);
    compare();
  endtask

  task automatic set_time(int h, int m, int s);
    cur_hour = to_bcd(h); cur_min = to_bcd(m); cur_sec = to_bcd(s);
  endtask

  task automatic set_0730();
    set_mode = 1;
    for (int i = 0; i < 30; i++) begin
      inc_min = 1; inc_hour = (i < 7);
      ah_exp = to_bcd((i < 7) ? i + 1 : 7);
      am_exp = to_bcd(i + 1);
      cyc("set_0730", 0, 0);
    end
    set_mode = 0;
  endtask

  task automatic fire_0730(string nm);
    set_time(7, 29, 59); cyc("pre_match", 0, 0);
    set_time(7, 30, 0);  cyc(nm, 1, 1);
  endtask

  task automatic do_reset(string nm);
    CLR_n = 1; ah_exp = 8'h00; am_exp = 8'h00;
    #2;
    async_chk(nm);
    CLR_n = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 24; i++) vecs.push_back('{1'b1, 1'b1, 1'b0, to_bcd((i + 1) % 24), 8'h00});
    for (int i = 0; i < 60; i++) vecs.push_back('{1'b1, 1'b0, 1'b1, 8'h00, to_bcd((i + 1) % 60)});
    for (int i = 0; i < 3; i++)  vecs.push_back('{1'b1, 1'b1, 1'b1, to_bcd(i + 1), to_bcd(i + 1)});
    for (int i = 0; i < 3; i++)  vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h03, 8'h03});

    #1 CLR_n = 1;
    #2 async_chk("reset");
    @(posedge clk); #1 CLR_n = 0;

    foreach (vecs[i]) begin
      set_mode = vecs[i].sm; inc_hour = vecs[i].ih; inc_min = vecs[i].im;
      ah_exp = vecs[i].eh; am_exp = vecs[i].em;
      cyc("set_vec", 0, 0);
    end
    set_mode = 0;
    do_reset("reset_clears_alarm");

    // Match, hold, then ring timeout.
    set_0730();
    alarm_en = 1;
    set_time(7, 29, 59); cyc("arm", 0, 0); cyc("armed", 0, 0);
    set_time(7, 30, 0);  cyc("match", 1, 1);
    repeat (3) cyc("match_held", 0, 1);
    for (int s = 1; s < 60; s++) begin
      set_time(7, 30, s); sec_tick = 1; cyc("ring_count", 0, 1);
    end
    set_time(7, 31, 0); sec_tick = 1; cyc("ring_last_tick", 0, 1);
    cyc("ring_timeout", 0, 0);
    cyc("armed_after_timeout", 0, 0);

    // Ack while match still high must not re-fire.
    fire_0730("match2");
    ack_btn = 1; cyc("ack", 0, 0);
    repeat (3) cyc("no_refire", 0, 0);

    // Snooze for 300 seconds then ring again.
    fire_0730("match3");
    snooze_btn = 1; cyc("snooze", 0, 0);
    set_time(8, 0, 0);
    for (int k = 0; k < 300; k++) begin
      sec_tick = 1; cyc("snooze_count", 0, 0);
    end
    cyc("snooze_ring", 1, 1);
    cyc("snooze_ring_hold", 0, 1);
    ack_btn = 1; cyc("snooze_ack", 0, 0);

    // Ack beats snooze.
    fire_0730("match4");
    ack_btn = 1; snooze_btn = 1; cyc("ack_and_snooze", 0, 0);
    cyc("ack_and_snooze_hold", 0, 0);

    // Async clear mid-RINGING, right on the bing cycle.
    fire_0730("match5");
    do_reset("clr_mid_ring");

    // Async clear mid-SNOOZE, then nothing fires later.
    set_0730();
    fire_0730("match6");
    snooze_btn = 1; cyc("snooze2", 0, 0);
    set_time(8, 0, 0);
    repeat (5) begin sec_tick = 1; cyc("snooze2_count", 0, 0); end
    do_reset("clr_mid_snooze");
    for (int k = 0; k < 310; k++) begin
      sec_tick = 1; cyc("no_bing_after_clr", 0, 0);
    end
    set_time(7, 29, 59); cyc("old_alarm_gone_pre", 0, 0);
    set_time(7, 30, 0);  cyc("old_alarm_gone", 0, 0);

    // alarm_en drops in the match-rise cycle (alarm now 00:00).
    set_time(23, 59, 59); cyc("pre_midnight", 0, 0);
    set_time(0, 0, 0); alarm_en = 0; cyc("en_fall_on_match", 0, 0);
    alarm_en = 1; cyc("en_back_idle", 0, 0);
    cyc("held_match_no_rise", 0, 0);

`ifdef HOURLY_CHIME_EN
    alarm_en = 0; chime_en = 1;
    set_time(9, 59, 59); cyc("pre_chime", 0, 0);
    set_time(10, 0, 0);  cyc("chime", 1, 0);
    cyc("chime_hold", 0, 0);
    set_mode = 1;
    for (int i = 0; i < 10; i++) begin
      inc_hour = 1; ah_exp = to_bcd(i + 1); cyc("set_10", 0, 0);
    end
    set_mode = 0; alarm_en = 1;
    set_time(9, 59, 59); cyc("arm_10", 0, 0); cyc("armed_10", 0, 0);
    set_time(10, 0, 0);  cyc("chime_and_alarm", 1, 1);
    cyc("chime_and_alarm_hold", 0, 1);
`else
    alarm_en = 0;
    set_time(9, 59, 59); cyc("pre_hour", 0, 0);
    set_time(10, 0, 0);  cyc("no_chime", 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/alarm_trigger.md
Name: alarm_trigger

Overview:
Alarm initiator for the digital-clock design. It holds the user-set alarm time in BCD and compares it against the running clock. On a match it issues the single-cycle `bing` pulse consumed by the LED/alarm responder. It also manages the ring, acknowledge and snooze sequencing, and sits between the timekeeping counters and the alarm output stage.

Parameters:
SNOOZE_MIN, 5, snooze length in minutes (legal 1..9)
RING_TIMEOUT_S, 60, seconds in RINGING before auto-return to ARMED
CNT_W, 10, width of internal seconds down-counter; must hold max(SNOOZE_MIN*60, RING_TIMEOUT_S)

Ports:
clk  input  1  system clock; all state on rising edge
CLR_n  input  1  reset, asynchronous, active-high
cur_hour  input  8  current hour, BCD 00..23
cur_min  input  8  current minute, BCD 00..59
cur_sec  input  8  current second, BCD 00..59
sec_tick  input  1  one-clk pulse per elapsed second
set_mode  input  1  1 = alarm-setting mode
inc_hour  input  1  one-clk pulse, alarm hour +1 (debounced upstream)
inc_min  input  1  one-clk pulse, alarm minute +1
alarm_en  input  1  level, alarm armed when 1
ack_btn  input  1  one-clk pulse, stop alarm
snooze_btn  input  1  one-clk pulse, snooze alarm
bing  output  1  one-clk pulse, start-alarm trigger to responder
alarm_hour  output  8  alarm hour, BCD, for display
alarm_min  output  8  alarm minute, BCD, for display
alarm_active  output  1  1 while state is RINGING

Behaviour:
- Reset values, asserted while CLR_n=1 regardless of clk:
  - bing=0, alarm_hour=8'h00, alarm_min=8'h00, alarm_active=0.
  - state=IDLE, down-counter=0, match register=0.
- Alarm setting:
  - Only while set_mode=1; inc_* pulses are ignored otherwise.
  - BCD increment with digit carry: x9 -> (x+1)0.
  - Wrap: hour 23->00, minute 59->00. Minute wrap does not carry into hour.
  - inc_hour and inc_min in the same cycle: both applied.
- Match: match_now = (cur_hour==alarm_hour) && (cur_min==alarm_min) && (cur_sec==8'h00). It is registered every cycle; match_rise = match_now & ~match_q.
- States:
  - IDLE: entered from any state when alarm_en=0 or set_mode=1. Counter cleared, no bing. Goes to ARMED when alarm_en=1 and set_mode=0.
  - ARMED: on match_rise -> RINGING; bing=1 for exactly one cycle, in the cycle after the match edge.
  - RINGING: alarm_active=1; counter loads RING_TIMEOUT_S on entry and decrements on sec_tick.
    - ack_btn -> ARMED.
    - snooze_btn -> SNOOZE.
    - counter reaching 0 -> ARMED.
  - SNOOZE: counter loads SNOOZE_MIN*60 on entry and decrements on sec_tick.
    - At 0 -> RINGING, with a one-cycle bing.
    - ack_btn -> ARMED, snooze cancelled.
- Priority, highest first: CLR_n > (alarm_en=0 | set_mode=1) > ack_btn > snooze_btn > timeout/match.
- bing is never asserted for two consecutive cycles. A match held for a full second produces one bing only (edge detect).
- Re-entering ARMED while match_now is still 1 does not re-fire, because no new rise occurs.
- alarm_en falling in the same cycle as match_rise: no bing.
- Asserting CLR_n mid-RINGING or mid-SNOOZE aborts immediately; bing and alarm_active drop asynchronously.

Optional Feature:
- Macro: HOURLY_CHIME_EN.
- Defined:
  - Adds input chime_en (1 bit).
  - When chime_en=1 and set_mode=0, a one-cycle bing is issued on the rise of (cur_min==8'h00 && cur_sec==8'h00), independent of alarm_en and state.
  - State is not changed by a chime.
  - If a chime and an alarm bing fall in the same cycle, a single bing pulse is issued.
- Undefined: port absent; no chime logic.

Decomposition:
- Package alarm_pkg:
  - state enum {IDLE, ARMED, RINGING, SNOOZE}.
  - BCD limits HOUR_MAX=8'h23, MIN_MAX=8'h59.
  - SEC_ZERO=8'h00.
- One sub-module, bcd_inc: combinational 2-digit BCD increment with wrap limit input. Instantiated twice, for hour and minute.

Test Plan:
1. set_mode=1, 24 inc_hour pulses from 00 -> alarm_hour steps 00..09,10..23, then 00; 60 inc_min pulses -> 59 wraps to 00; inc_* with set_mode=0 -> no change.
2. Alarm 07:30, alarm_en=1; clock reaches 07:30:00 -> exactly one bing cycle, alarm_active=1; remains 1 through 07:30:59 with no second bing.
3. RINGING, snooze_btn -> SNOOZE; after 300 sec_tick -> one bing, RINGING again; then ack_btn -> ARMED, alarm_active=0.
4. RINGING with no buttons -> after 60 sec_tick, ARMED, alarm_active=0, no bing.
5. ack_btn and snooze_btn in the same cycle -> ARMED; CLR_n pulse mid-SNOOZE -> all outputs 0, alarm regs 00:00, no later bing.
6. HOURLY_CHIME_EN, chime_en=1, alarm_en=0, clock 09:59:59 -> 10:00:00 -> one bing; alarm set to 10:00 with alarm_en=1 -> single bing only.
